// File: rtl/norm_shift_pipe_if.sv
// Stream bundle between the leading-one detector, the normalizer and the float-pack stage.
// The master side drives words in and accepts results; the slave side is the normalizer.
interface norm_shift_pipe_if #(
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [5:0]       in_pos;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_pos, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_pos, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_zero
    );
endinterface

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: shifts a word so its leading one sits at bit 31, derives a biased
// exponent, flags zero words, and checks the detector's position against the data itself.
module norm_shift_pipe #(
    parameter int EXP_W    = 8,
    parameter int EXP_BIAS = 127,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    norm_shift_pipe_if.slave       bus,
    input  logic                   clr_stats,
    output logic                   err_pos,
    output logic [CNT_W-1:0]       cnt_words,
    output logic [CNT_W-1:0]       cnt_zero
);

    logic             s1_valid;
    logic [31:0]      s1_data;
    logic [5:0]       s1_pos;
    logic             s1_zero;
    logic             s1_bad;
    logic [4:0]       lead_idx;
    logic [31:0]      exp_full;

    logic             s2_valid;
    logic [31:0]      s2_data;
    logic [EXP_W-1:0] s2_exp;
    logic             s2_zero;

    logic             s2_adv;
    logic             s1_adv;
    logic             out_fire;

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_exp   = s2_exp;
    assign bus.out_zero  = s2_zero;

    // A position is consistent only if shifting the leading-one bit down to bit 0 leaves exactly 1.
    always_comb begin
        s1_zero  = (s1_data == 32'd0);
        lead_idx = 5'd31 - s1_pos[4:0];
        s1_bad   = !s1_zero && (s1_pos[5] || ((s1_data >> lead_idx) != 32'd1));
        exp_full = 32'(EXP_BIAS) + 32'd31 - {26'd0, s1_pos};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= 32'd0;
            s1_pos   <= 6'd0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_pos  <= bus.in_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= 32'd0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_zero) begin
                    s2_data <= 32'd0;
                    s2_exp  <= '0;
                    s2_zero <= 1'b1;
                end else if (s1_bad) begin
                    s2_data <= s1_data;
                    s2_exp  <= '0;
                    s2_zero <= 1'b0;
                end else begin
                    s2_data <= s1_data << s1_pos[4:0];
                    s2_exp  <= exp_full[EXP_W-1:0];
                    s2_zero <= 1'b0;
                end
            end
        end
    end

    // clr_stats wins over any same-cycle set or increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pos   <= 1'b0;
            cnt_words <= '0;
            cnt_zero  <= '0;
        end else if (clr_stats) begin
            err_pos   <= 1'b0;
            cnt_words <= '0;
            cnt_zero  <= '0;
        end else begin
            if (s1_valid && s1_bad && s2_adv) begin
                err_pos <= 1'b1;
            end
            if (out_fire && (cnt_words != {CNT_W{1'b1}})) begin
                cnt_words <= cnt_words + 1'b1;
            end
            if (out_fire && s2_zero && (cnt_zero != {CNT_W{1'b1}})) begin
                cnt_zero <= cnt_zero + 1'b1;
            end
        end
    end

endmodule

// File: doc/norm_shift_pipe.md
Name: norm_shift_pipe

Overview:
- Downstream consumer of the 32-bit leading-one detector.
- Takes a data word plus its detected leading-one position (count of leading zeros from bit 31).
- Left-normalizes the word so the leading one lands at bit 31, and produces a biased exponent and a zero flag.
- 2-stage valid/ready pipeline with full backpressure, per-word position consistency check, and saturating statistics counters. Feeds the float-pack stage.

Parameters:
- EXP_W, 8, width of out_exp.
- EXP_BIAS, 127, bias added to bit index of leading one (out_exp = EXP_BIAS + 31 - pos).
- CNT_W, 16, width of statistics counters (saturating).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  raw word.
- in_pos  input  6  leading-one position from detector (0 = bit 31 set).
- out_valid  output  1  normalized result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  in_data << in_pos (bit 31 = 1 unless zero).
- out_exp  output  EXP_W  EXP_BIAS + 31 - in_pos, truncated to EXP_W; 0 when zero.
- out_zero  output  1  in_data was all zeros.
- err_pos  output  1  sticky: a nonzero word arrived with an inconsistent in_pos.
- cnt_words  output  CNT_W  words delivered at output, saturating.
- cnt_zero  output  CNT_W  zero words delivered at output, saturating.
- clr_stats  input  1  synchronous clear of err_pos, cnt_words, cnt_zero.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, including out_valid, err_pos and counters.
  - in_ready reads 1 after reset is released.
  - Both pipeline valids clear.
  - Words in flight when reset asserts are dropped with no output.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready; in_ready = !s1_valid || s2_adv (combinational from out_ready).
  - Throughput 1 word/cycle with no backpressure; latency 2 cycles from input accept to out_valid.
  - out_data, out_exp and out_zero hold stable while out_valid && !out_ready.
  - No drop and no duplication under any out_ready pattern.
- Stage 1 (capture):
  - Registers data and pos; zero = (data == 0).
  - Computes pos_bad = !zero && (pos > 31 || data[31-pos] == 0 || any data bit above 31-pos set).
- Stage 2 (normalize):
  - Zero word: out_data = 0, out_exp = 0, out_zero = 1.
  - pos_bad word: out_data = stage-1 data unshifted, out_exp = 0, out_zero = 0.
  - Otherwise: out_data = data << pos, out_exp = EXP_BIAS + 31 - pos modulo 2^EXP_W, out_zero = 0.
  - pos is ignored for zero words; the detector reports 0 for both zero and bit-31 words, and this is not an error.
- err_pos:
  - Set in the cycle a pos_bad word advances from stage 1 to stage 2.
  - Remains set until clr_stats or reset.
- Counters:
  - cnt_words increments on each output transfer; cnt_zero increments on output transfer with out_zero = 1.
  - Both saturate at 2^CNT_W - 1.
- clr_stats:
  - Clears err_pos and both counters next edge; it has priority over a same-cycle increment or set.
  - Pipeline contents are unaffected.

Test Plan:
- Single word, out_ready = 1: in_data = 0x0000_1234, in_pos = 19 -> 2 cycles later out_data = 0x91A0_0000, out_exp = 139, out_zero = 0, cnt_words = 1.
- Boundaries: in_data = 0x8000_0000/pos 0 -> out_data unchanged, exp 158; in_data = 0x0000_0001/pos 31 -> out_data = 0x8000_0000, exp 127; in_data = 0/pos 0 -> out_zero = 1, exp 0, cnt_zero = 1, err_pos = 0.
- Backpressure: stream 8 words back-to-back while out_ready toggles 1,0,0,1,0,1,... -> all 8 emerge in order and unmodified; in_ready low only when both stages full and out_ready = 0; outputs stable while stalled.
- Bad position: in_data = 0x0000_00F0, in_pos = 20 -> err_pos = 1 and stays 1; out_data = 0x0000_00F0, exp 0; next pulse clr_stats -> err_pos = 0, cnt_words = 0.
- Saturation: with CNT_W = 4, pass 20 words -> cnt_words holds 15.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid drops immediately and asynchronously; after release no stale word emerges and counters read 0.
